// File: rtl/tick_tock_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_tock_scheduler
//  Purpose  : Epoch sequencer for the tick-tock-tokens processor array.
//             Shares one processor-core port and one network spike port
//             among NUM_PROCESSORS logical processors. Every epoch runs
//             INJECT (drain buffered external tokens), TICK (tick each
//             processor once), TOCK (broadcast every processor that fired,
//             lowest id first) and DONE (one-cycle completion pulse).
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             run                 - epoch start request (sampled in IDLE)
//             ext_valid/ext_id/ext_ready - external token push handshake
//             proc_op/proc_id     - processor-core command (NOP/TOKEN/TICK)
//             proc_fire           - fire flag returned during TICK
//             net_valid/net_src_id/net_ready - spike broadcast handshake
//             state, busy, epoch_done - status
//  Revision : 1.0 - initial release
// ============================================================================
module tick_tock_scheduler #(
    parameter int NUM_PROCESSORS = 16,
    parameter int PROC_ID_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     ext_valid,
    input  logic [PROC_ID_WIDTH-1:0] ext_id,
    output logic                     ext_ready,
    output logic [1:0]               proc_op,
    output logic [PROC_ID_WIDTH-1:0] proc_id,
    input  logic                     proc_fire,
    output logic                     net_valid,
    output logic [PROC_ID_WIDTH-1:0] net_src_id,
    input  logic                     net_ready,
    output logic [2:0]               state,
    output logic                     busy,
    output logic                     epoch_done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_INJECT = 3'd1;
    localparam logic [2:0] c_TICK   = 3'd2;
    localparam logic [2:0] c_TOCK   = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_TOKEN = 2'b01;
    localparam logic [1:0] c_OP_TICK  = 2'b10;

    // One extra bit so ids up to 2**PROC_ID_WIDTH-1 compare correctly.
    localparam logic [PROC_ID_WIDTH:0]   c_NUM_EXT  = (PROC_ID_WIDTH+1)'(NUM_PROCESSORS);
    localparam logic [PROC_ID_WIDTH-1:0] c_CNT_LAST = PROC_ID_WIDTH'(NUM_PROCESSORS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]                r_state;
    logic [PROC_ID_WIDTH-1:0]  r_cnt;
    logic [NUM_PROCESSORS-1:0] r_mask;
    logic [PROC_ID_WIDTH-1:0]  r_fifo_mem [0:1];
    logic                      r_rd_ptr;
    logic                      r_wr_ptr;
    logic [1:0]                r_count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push_hs;
    logic                      w_push;
    logic                      w_pop;
    logic [1:0]                w_count_next;
    logic                      w_any_fire;
    logic [PROC_ID_WIDTH-1:0]  w_low_id;
    logic                      w_net_hs;
    logic [NUM_PROCESSORS-1:0] w_mask_next;
    logic [2:0]                w_state_next;

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    assign w_push_hs = ext_valid && !w_full;
    // Out-of-range ids complete the handshake but are dropped here.
    assign w_push    = w_push_hs && ({1'b0, ext_id} < c_NUM_EXT);
    assign w_pop     = (r_state == c_INJECT) && !w_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Priority encoder: scanning downward so the lowest set bit wins.
    always_comb begin
        w_low_id = '0;
        for (int i = NUM_PROCESSORS - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_id = PROC_ID_WIDTH'(i);
            end
        end
    end

    assign w_any_fire = |r_mask;
    assign w_net_hs   = (r_state == c_TOCK) && w_any_fire && net_ready;

    // Mask update: capture fire during TICK, retire broadcast bit in TOCK.
    // A compare loop avoids indexing the mask with a possibly wider id.
    always_comb begin
        w_mask_next = r_mask;
        for (int i = 0; i < NUM_PROCESSORS; i++) begin
            if ((r_state == c_TICK) && (r_cnt == PROC_ID_WIDTH'(i))) begin
                w_mask_next[i] = proc_fire;
            end
            if (w_net_hs && (w_low_id == PROC_ID_WIDTH'(i))) begin
                w_mask_next[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (run) begin
                    w_state_next = w_empty ? c_TICK : c_INJECT;
                end
            end
            c_INJECT: begin
                // Leave only once this cycle's pop drains the FIFO and no
                // new token arrived alongside it.
                if (w_count_next == 2'd0) begin
                    w_state_next = c_TICK;
                end
            end
            c_TICK: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_TOCK;
                end
            end
            c_TOCK: begin
                if (!w_any_fire) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            if ((r_state == c_TICK) && (r_cnt != c_CNT_LAST)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= ext_id;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        proc_op = c_OP_NOP;
        proc_id = '0;
        case (r_state)
            c_INJECT: begin
                proc_op = c_OP_TOKEN;
                proc_id = r_fifo_mem[r_rd_ptr];
            end
            c_TICK: begin
                proc_op = c_OP_TICK;
                proc_id = r_cnt;
            end
            default: begin
                proc_op = c_OP_NOP;
                proc_id = '0;
            end
        endcase
    end

    assign ext_ready  = !w_full;
    assign net_valid  = (r_state == c_TOCK) && w_any_fire;
    assign net_src_id = (r_state == c_TOCK) ? w_low_id : '0;
    assign state      = r_state;
    assign busy       = (r_state != c_IDLE);
    assign epoch_done = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tick_tock_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_tock_scheduler
//  Purpose  : Directed self-checking bench for tick_tock_scheduler
//             (NUM_PROCESSORS=16, PROC_ID_WIDTH=5 so out-of-range ids fit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_tock_scheduler;

    localparam int N  = 16;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          ext_valid = 1'b0;
    logic [PW-1:0] ext_id = '0;
    logic          ext_ready;
    logic [1:0]    proc_op;
    logic [PW-1:0] proc_id;
    logic          proc_fire = 1'b0;
    logic          net_valid;
    logic [PW-1:0] net_src_id;
    logic          net_ready = 1'b0;
    logic [2:0]    state;
    logic          busy;
    logic          epoch_done;

    int n_checks = 0;
    int n_pass   = 0;

    tick_tock_scheduler #(.NUM_PROCESSORS(N), .PROC_ID_WIDTH(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ext_valid  (ext_valid),
        .ext_id     (ext_id),
        .ext_ready  (ext_ready),
        .proc_op    (proc_op),
        .proc_id    (proc_id),
        .proc_fire  (proc_fire),
        .net_valid  (net_valid),
        .net_src_id (net_src_id),
        .net_ready  (net_ready),
        .state      (state),
        .busy       (busy),
        .epoch_done (epoch_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the 16 TICK cycles, firing the processors set in fmask.
    task automatic tick_phase(input logic [N-1:0] fmask);
        for (int i = 0; i < N; i++) begin
            chk("tick_op", 32'(proc_op), 32'd2);
            chk("tick_id", 32'(proc_id), 32'(i));
            chk("tick_nv", 32'(net_valid), 32'd0);
            proc_fire = fmask[i];
            tick();
        end
        proc_fire = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(ext_ready), 32'd1);
        chk("rst_op", 32'(proc_op), 32'd0);
        chk("rst_id", 32'(proc_id), 32'd0);
        chk("rst_nv", 32'(net_valid), 32'd0);
        chk("rst_src", 32'(net_src_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(epoch_done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- empty epoch ----------------
        run = 1'b1;                        // cycle 0
        tick();
        run = 1'b0;                        // cycle 1
        chk("e1_state", 32'(state), 32'd2);
        tick_phase('0);                    // now cycle 17
        chk("e1_tock", 32'(state), 32'd3);
        chk("e1_tock_nv", 32'(net_valid), 32'd0);
        tick();                            // cycle 18
        chk("e1_done", 32'(epoch_done), 32'd1);
        chk("e1_done_st", 32'(state), 32'd4);
        tick();                            // cycle 19
        chk("e1_idle", 32'(state), 32'd0);
        chk("e1_done_off", 32'(epoch_done), 32'd0);
        chk("e1_busy", 32'(busy), 32'd0);

        // ---------------- tokens 3,7 + fires 2,9,15 with stall ----------------
        ext_valid = 1'b1; ext_id = 5'd3;
        chk("p1_ready", 32'(ext_ready), 32'd1);
        tick();
        ext_id = 5'd7;
        chk("p2_ready", 32'(ext_ready), 32'd1);
        tick();
        ext_valid = 1'b0;
        chk("full_ready", 32'(ext_ready), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("inj0_state", 32'(state), 32'd1);
        chk("inj0_op", 32'(proc_op), 32'd1);
        chk("inj0_id", 32'(proc_id), 32'd3);
        chk("inj0_ready", 32'(ext_ready), 32'd0);
        tick();
        chk("inj1_op", 32'(proc_op), 32'd1);
        chk("inj1_id", 32'(proc_id), 32'd7);
        chk("inj1_ready", 32'(ext_ready), 32'd1);
        tick();
        tick_phase(16'b1000_0010_0000_0100);
        for (int k = 0; k < 3; k++) begin
            chk("stall_state", 32'(state), 32'd3);
            chk("stall_nv", 32'(net_valid), 32'd1);
            chk("stall_src", 32'(net_src_id), 32'd2);
            tick();
        end
        net_ready = 1'b1;
        chk("b0_src", 32'(net_src_id), 32'd2);
        tick();
        chk("b1_nv", 32'(net_valid), 32'd1);
        chk("b1_src", 32'(net_src_id), 32'd9);
        tick();
        chk("b2_src", 32'(net_src_id), 32'd15);
        tick();
        chk("b3_nv", 32'(net_valid), 32'd0);
        chk("b3_state", 32'(state), 32'd3);
        tick();
        chk("e2_done", 32'(epoch_done), 32'd1);
        tick();
        chk("e2_idle", 32'(state), 32'd0);
        net_ready = 1'b0;

        // ---------------- out-of-range ids discarded ----------------
        ext_valid = 1'b1; ext_id = 5'd20;
        chk("bad1_ready", 32'(ext_ready), 32'd1);
        tick();
        chk("bad2_ready", 32'(ext_ready), 32'd1);
        tick();
        ext_valid = 1'b0;
        chk("bad_empty", 32'(ext_ready), 32'd1);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("bad_no_inj", 32'(state), 32'd2);
        tick_phase('0);
        chk("e3_tock", 32'(state), 32'd3);
        tick();
        tick();
        chk("e3_idle", 32'(state), 32'd0);

        // ---------------- push during INJECT extends it ----------------
        ext_valid = 1'b1; ext_id = 5'd5;
        tick();
        ext_valid = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("ext_inj0_id", 32'(proc_id), 32'd5);
        ext_valid = 1'b1; ext_id = 5'd11;
        tick();
        ext_valid = 1'b0;
        chk("ext_inj1_state", 32'(state), 32'd1);
        chk("ext_inj1_id", 32'(proc_id), 32'd11);
        tick();
        tick_phase('0);
        tick();                            // DONE
        chk("e4_done", 32'(epoch_done), 32'd1);
        run = 1'b1;                        // held high: back-to-back epoch
        tick();
        chk("b2b_idle", 32'(state), 32'd0);
        tick();
        run = 1'b0;
        chk("b2b_tick", 32'(state), 32'd2);

        // ---------------- async reset mid-TOCK ----------------
        tick_phase(16'b0000_0000_0001_0000);
        chk("pre_rst_nv", 32'(net_valid), 32'd1);
        chk("pre_rst_src", 32'(net_src_id), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_nv", 32'(net_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        net_ready = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("e6_state", 32'(state), 32'd2);
        tick_phase(16'b0000_0000_0100_0000);
        chk("e6_src", 32'(net_src_id), 32'd6);
        chk("e6_nv", 32'(net_valid), 32'd1);
        tick();
        chk("e6_clear", 32'(net_valid), 32'd0);
        tick();
        chk("e6_done", 32'(epoch_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_tock_scheduler.md
# tick_tock_scheduler

Epoch sequencer for the tick-tock-tokens processor array. It time-multiplexes a single shared processor-core port and the shared network spike port across `NUM_PROCESSORS` logical processors. Each epoch runs four steps in order: inject buffered external tokens, tick every processor once, broadcast every processor that fired, then signal completion. It sits between `tt_um_jleugeri_ticktocktokens` top-level I/O, the processor core and the network.

## Interface
- `NUM_PROCESSORS`, default 16: number of logical processors. Must be ≥ 2; need not be a power of two.
- `PROC_ID_WIDTH`, default 4: width of processor ids. Must be ≥ `$clog2(NUM_PROCESSORS)`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `run` in 1: start request, sampled only in IDLE.
- `ext_valid` in 1: external token request.
- `ext_id` in `PROC_ID_WIDTH`: target processor for the external token.
- `ext_ready` out 1: token FIFO can accept a request.
- `proc_op` out 2: processor-core command; 00 NOP, 01 TOKEN, 10 TICK, 11 reserved and never driven.
- `proc_id` out `PROC_ID_WIDTH`: processor addressed by `proc_op`.
- `proc_fire` in 1: the addressed processor fires; valid in the same cycle as `proc_op`=TICK.
- `net_valid` out 1: spike broadcast request.
- `net_src_id` out `PROC_ID_WIDTH`: id of the processor whose spike is being broadcast.
- `net_ready` in 1: network accepts the spike.
- `state` out 3: current state; IDLE=0, INJECT=1, TICK=2, TOCK=3, DONE=4.
- `busy` out 1: high whenever state ≠ IDLE.
- `epoch_done` out 1: one-cycle pulse in DONE.

## Operation
- State register, tick counter `cnt`, fire mask `mask[NUM_PROCESSORS-1:0]` and a 2-entry token FIFO.
- All outputs decode from registered state only. No input-to-output combinational path exists.
- Token FIFO:
  - `ext_ready` = !full.
  - Push on `ext_valid && ext_ready`, in any state.
  - A push with `ext_id` ≥ `NUM_PROCESSORS` is handshaken but discarded: not stored, no TOKEN is ever issued for it.
  - A push and a pop in the same cycle is legal when the FIFO is not full; the count is unchanged.
- IDLE:
  - Drives `proc_op`=NOP and `net_valid`=0.
  - If `run`=1: go to INJECT if the FIFO is non-empty, otherwise to TICK.
- INJECT:
  - Drives `proc_op`=TOKEN and `proc_id`=FIFO head, and pops the FIFO every cycle.
  - Exits to TICK after the cycle that pops the last entry with no concurrent push. Pushes arriving during INJECT extend it.
- TICK:
  - `cnt` runs 0..`NUM_PROCESSORS`-1, one value per cycle.
  - Drives `proc_op`=TICK and `proc_id`=`cnt`.
  - Each cycle, `mask[cnt]` <= `proc_fire`.
  - After `cnt`=`NUM_PROCESSORS`-1, go to TOCK and clear `cnt`.
- TOCK:
  - `net_valid` = |mask; `net_src_id` = index of the lowest set bit of `mask`.
  - On `net_valid && net_ready`, clear that bit.
  - Once valid is asserted, `net_src_id` and `net_valid` stay stable until the handshake completes.
  - Go to DONE in the cycle `mask` is zero. An empty mask gives exactly one TOCK cycle with `net_valid`=0.
  - Lower ids always broadcast first.
- DONE: `epoch_done`=1 for one cycle, then go to IDLE.
- Tokens pushed after INJECT has exited stay buffered for the next epoch.

## Timing
- Reset values (all asynchronous): state=IDLE, `cnt`=0, `mask`=0, FIFO empty.
  - Outputs in reset: `ext_ready`=1, `proc_op`=00, `proc_id`=0, `net_valid`=0, `net_src_id`=0, `busy`=0, `epoch_done`=0.
- Asserting `rst_n` low mid-epoch aborts immediately and discards FIFO contents and the pending mask.
- Epoch with an empty FIFO, no fires and `run` seen at cycle 0:
  - TICK cycles 1..N, TOCK at N+1, DONE at N+2, IDLE at N+3.
- Each injected token adds one cycle. Each fired processor adds at least one TOCK cycle per broadcast (1 if `net_ready` is held high).
- With `run` held high, back-to-back epochs are separated by exactly one IDLE cycle.
- `proc_fire` is sampled on the clock edge that ends its TICK cycle.

## Test plan
- Reset, then `run`=1 for one cycle, N=16, `proc_fire`=0 → `proc_op`=TICK with ids 0..15 in cycles 1..16; `net_valid` never asserts; `epoch_done` at cycle 18.
- Push ext ids 3 then 7 in IDLE, then `run` → TOKEN 3, TOKEN 7, then TICK 0..15; after the second push `ext_ready`=0 until the first pop.
- `proc_fire`=1 on ids 2, 9 and 15; `net_ready` low for 3 cycles, then high → `net_src_id`=2 held stable while stalled, then 9, then 15, then DONE.
- Push with `ext_id`=20 at N=16 → `ext_ready`=1 and handshake completes; FIFO stays empty; no TOKEN is issued.
- Push during INJECT while the FIFO holds one entry → INJECT extends by one cycle and both ids are issued in order.
- Drive `rst_n`=0 mid-TOCK while `net_valid`=1 → `net_valid`=0 and state=IDLE immediately; the next epoch broadcasts only new fires.
